// File: rtl/ariane_pkg.sv
// Types shared between the fetch stage and decode: branch prediction, fetch entries, fetch FSM states.
package ariane_pkg;

  localparam int unsigned FETCH_FIFO_DEPTH = 4;

  typedef struct packed {
    logic        valid;
    logic [63:0] predict_address;
    logic        predict_taken;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [63:0]        address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    logic               ex_valid;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RVALID,
    ABORT
  } fetch_state_e;

  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// I-cache request/response channel: the fetch stage is master, the I-cache is slave.
interface if_stage_if;
  logic        req;
  logic [63:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ex;

  modport master (output req, addr, input gnt, rvalid, rdata, ex);
  modport slave  (input req, addr, output gnt, rvalid, rdata, ex);
endinterface

// File: rtl/fetch_fifo.sv
// Generic FIFO with flush; head is readable the cycle after a push and reads zero when empty.
module fetch_fifo #(
  parameter type         dtype_t = logic,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  dtype_t                 data_i,
  input  logic                   pop_i,
  output dtype_t                 data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  dtype_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    data_o = '0;
    if (!empty_o) data_o = mem_q[rptr_q];
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one outstanding I-cache request, responses buffered in a fetch FIFO.
// A request is only issued when the FIFO is guaranteed room for its response.
module if_stage
  import ariane_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [63:0]        fetch_address_i,
  input  logic               fetch_valid_i,
  input  branchpredict_sbe_t branch_predict_i,
  output logic               if_ready_o,
  if_stage_if.master         icache,
  output fetch_entry_t       fetch_entry_o,
  output logic               fetch_entry_valid_o,
  input  logic               fetch_ack_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [63:0]        tag_addr_q;
  branchpredict_sbe_t tag_bp_q;
  logic               can_issue, req, push, pop, space;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_cnt;
  logic [CW:0]        need;
  fetch_entry_t       push_entry;

  // The outstanding response already owns a slot; popping this cycle frees nothing yet.
  assign need  = {1'b0, fifo_cnt} + {{CW{1'b0}}, (state_q == WAIT_RVALID)} + (CW+1)'(1);
  assign space = (need <= (CW+1)'(FIFO_DEPTH));

  assign can_issue = (state_q == IDLE) | ((state_q == WAIT_RVALID) & icache.rvalid);
  assign req       = can_issue & fetch_valid_i & space & ~flush_i & rst_ni;

  assign icache.req          = req;
  assign icache.addr         = word_align(fetch_address_i);
  assign if_ready_o          = req & icache.gnt;
  assign fetch_entry_valid_o = ~fifo_empty;
  assign pop                 = fetch_entry_valid_o & fetch_ack_i;

  always_comb begin
    push_entry                = '0;
    push_entry.address        = tag_addr_q;
    push_entry.instruction    = icache.ex ? 32'd0 : icache.rdata;
    push_entry.branch_predict = tag_bp_q;
    if (icache.ex) push_entry.branch_predict.valid = 1'b0;
    push_entry.ex_valid       = icache.ex;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_ready_o) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (flush_i) begin
          state_d = icache.rvalid ? IDLE : ABORT;
        end else if (icache.rvalid) begin
          push    = 1'b1;
          state_d = if_ready_o ? WAIT_RVALID : IDLE;
        end
      end
      ABORT: begin
        if (icache.rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tag_addr_q <= '0;
      tag_bp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (if_ready_o) begin
        tag_addr_q <= fetch_address_i;
        tag_bp_q   <= branch_predict_i;
      end
    end
  end

  fetch_fifo #(
    .dtype_t (fetch_entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) i_fetch_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (fetch_entry_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push && fifo_full) |-> pop);

endmodule

// File: tb/tb_if_stage.sv
// Directed and random checks of if_stage against a queue-based model of the fetch buffer.
module tb_if_stage;
  import ariane_pkg::*;

  localparam int DEPTH = 4;

  logic               clk_i, rst_ni, flush_i, fetch_valid_i, fetch_ack_i;
  logic [63:0]        fetch_address_i;
  branchpredict_sbe_t branch_predict_i;
  logic               if_ready_o, fetch_entry_valid_o;
  fetch_entry_t       fetch_entry_o;

  if_stage_if ifc ();

  if_stage #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .fetch_address_i     (fetch_address_i),
    .fetch_valid_i       (fetch_valid_i),
    .branch_predict_i    (branch_predict_i),
    .if_ready_o          (if_ready_o),
    .icache              (ifc),
    .fetch_entry_o       (fetch_entry_o),
    .fetch_entry_valid_o (fetch_entry_valid_o),
    .fetch_ack_i         (fetch_ack_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int                 errors = 0;
  int                 checks = 0;
  int                 dut_grants = 0;
  logic               last_ready;
  logic [63:0]        pc;

  // Model: entries the consumer should see, plus the single in-flight request.
  fetch_entry_t       mq[$];
  bit                 m_out, m_abort;
  logic [63:0]        m_tag_addr;
  branchpredict_sbe_t m_tag_bp;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_req();
    bit room = (mq.size() + int'(m_out) + 1) <= DEPTH;
    return rst_ni && fetch_valid_i && !flush_i && room && (!m_out || (!m_abort && ifc.rvalid));
  endfunction

  task automatic check_outputs();
    bit er = model_req();
    chk("icache_req", 256'(ifc.req), 256'(er));
    chk("if_ready", 256'(if_ready_o), 256'(er && ifc.gnt));
    if (er) chk("icache_addr", 256'(ifc.addr), 256'({fetch_address_i[63:2], 2'b00}));
    chk("entry_valid", 256'(fetch_entry_valid_o), 256'(mq.size() != 0));
    if (mq.size() != 0) chk("entry", 256'(fetch_entry_o), 256'(mq[0]));
    last_ready = if_ready_o;
    if (if_ready_o) dut_grants++;
  endtask

  task automatic update_model(input bit er);
    fetch_entry_t e;
    if (flush_i) begin
      mq.delete();
      if (m_out && !ifc.rvalid) m_abort = 1'b1;
      else begin m_out = 1'b0; m_abort = 1'b0; end
    end else begin
      if (mq.size() != 0 && fetch_ack_i) void'(mq.pop_front());
      if (m_out && ifc.rvalid) begin
        if (!m_abort) begin
          e.address        = m_tag_addr;
          e.instruction    = ifc.ex ? 32'd0 : ifc.rdata;
          e.branch_predict = m_tag_bp;
          if (ifc.ex) e.branch_predict.valid = 1'b0;
          e.ex_valid       = ifc.ex;
          mq.push_back(e);
        end
        m_out = 1'b0;
        m_abort = 1'b0;
      end
    end
    if (er && ifc.gnt) begin
      m_out = 1'b1;
      m_abort = 1'b0;
      m_tag_addr = fetch_address_i;
      m_tag_bp = branch_predict_i;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    bit er;
    #1;
    check_outputs();
    er = model_req();
    @(posedge clk_i);
    update_model(er);
    @(negedge clk_i);
  endtask

  task automatic cyc_auto();
    ifc.rvalid = m_out;
    ifc.rdata  = $urandom;
    branch_predict_i = {1'b1, {$urandom, $urandom}, 1'($urandom)};
    cycle();
    ifc.rvalid = 1'b0;
  endtask

  task automatic idle_inputs();
    fetch_valid_i = 0; flush_i = 0; fetch_ack_i = 0;
    ifc.gnt = 0; ifc.rvalid = 0; ifc.ex = 0; ifc.rdata = '0;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    fetch_valid_i = 1'b1;
    ifc.gnt = 1'b1;
    fetch_address_i = 64'h100;
    branch_predict_i = '0;
    m_out = 0; m_abort = 0; m_tag_addr = '0; m_tag_bp = '0;
    @(negedge clk_i);
    #1;
    chk("rst_req", 256'(ifc.req), 256'(0));
    chk("rst_ready", 256'(if_ready_o), 256'(0));
    chk("rst_valid", 256'(fetch_entry_valid_o), 256'(0));
    chk("rst_entry", 256'(fetch_entry_o), 256'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle_inputs();

    // Back-to-back grant/rvalid stream
    pc = 64'h8000_0000; fetch_valid_i = 1; ifc.gnt = 1; fetch_ack_i = 1; dut_grants = 0;
    repeat (8) begin
      fetch_address_i = pc;
      cyc_auto();
      if (last_ready) pc += 64'd4;
    end
    chk("b2b_grants", 256'(dut_grants), 256'(8));
    chk("b2b_pc", 256'(pc), 256'(64'h8000_0020));
    fetch_valid_i = 0;
    repeat (3) cyc_auto();

    // Backpressure with no acks
    fetch_valid_i = 1; ifc.gnt = 1; fetch_ack_i = 0; dut_grants = 0;
    repeat (10) begin fetch_address_i = pc; cyc_auto(); if (last_ready) pc += 64'd4; end
    chk("bp_grants", 256'(dut_grants), 256'(4));
    #1 chk("bp_req_low", 256'(ifc.req), 256'(0));
    @(negedge clk_i);
    fetch_ack_i = 1; cyc_auto(); fetch_ack_i = 0; dut_grants = 0;
    repeat (6) begin fetch_address_i = pc; cyc_auto(); if (last_ready) pc += 64'd4; end
    chk("bp_one_more", 256'(dut_grants), 256'(1));
    fetch_valid_i = 0; fetch_ack_i = 1;
    repeat (6) cyc_auto();

    // Grant stall
    fetch_valid_i = 1; fetch_address_i = 64'h1000; ifc.gnt = 0; dut_grants = 0;
    repeat (3) cyc_auto();
    chk("stall_no_grant", 256'(dut_grants), 256'(0));
    ifc.gnt = 1; cyc_auto();
    chk("stall_accept", 256'(dut_grants), 256'(1));
    fetch_valid_i = 0; ifc.gnt = 0;
    repeat (3) cyc_auto();

    // Flush with a request in flight
    fetch_valid_i = 1; fetch_address_i = 64'h3000; ifc.gnt = 1; fetch_ack_i = 0;
    cycle();
    dut_grants = 0;
    flush_i = 1; cycle(); flush_i = 0;
    cycle();
    ifc.rvalid = 1; ifc.rdata = 32'hDEAD_BEEF; cycle(); ifc.rvalid = 0;
    chk("flush_no_grant", 256'(dut_grants), 256'(0));
    chk("flush_empty", 256'(fetch_entry_valid_o), 256'(0));
    cycle();
    chk("flush_resume", 256'(dut_grants), 256'(1));
    fetch_valid_i = 0; fetch_ack_i = 1;
    repeat (3) cyc_auto();
    fetch_ack_i = 0;

    // Fetch access fault
    fetch_valid_i = 1; fetch_address_i = 64'h2000; ifc.gnt = 1;
    branch_predict_i = {1'b1, 64'h4000, 1'b1};
    cycle();
    fetch_valid_i = 0; ifc.rvalid = 1; ifc.ex = 1; ifc.rdata = 32'h1234_5678;
    cycle();
    ifc.rvalid = 0; ifc.ex = 0;
    #1;
    chk("fault_addr", 256'(fetch_entry_o.address), 256'(64'h2000));
    chk("fault_ex", 256'(fetch_entry_o.ex_valid), 256'(1));
    chk("fault_instr", 256'(fetch_entry_o.instruction), 256'(0));
    chk("fault_bp", 256'(fetch_entry_o.branch_predict.valid), 256'(0));
    @(negedge clk_i);
    fetch_ack_i = 1; cycle();

    // Random traffic
    repeat (400) begin
      fetch_valid_i    = ($urandom % 4) != 0;
      fetch_address_i  = {$urandom, $urandom};
      branch_predict_i = {1'($urandom), {$urandom, $urandom}, 1'($urandom)};
      ifc.gnt          = 1'($urandom);
      ifc.rvalid       = m_out ? 1'($urandom) : 1'b0;
      ifc.rdata        = $urandom;
      ifc.ex           = ($urandom % 8) == 0;
      fetch_ack_i      = ($urandom % 3) != 0;
      flush_i          = ($urandom % 16) == 0;
      cycle();
    end
    idle_inputs();
    fetch_ack_i = 1;
    repeat (6) cyc_auto();

    // Async reset with 3 buffered entries and one request outstanding
    fetch_ack_i = 0; fetch_valid_i = 1; ifc.gnt = 1; pc = 64'h5000;
    repeat (4) begin fetch_address_i = pc; cyc_auto(); pc += 64'd4; end
    chk("pre_rst_fill", 256'(mq.size()), 256'(3));
    chk("pre_rst_valid", 256'(fetch_entry_valid_o), 256'(1));
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_req", 256'(ifc.req), 256'(0));
    chk("arst_ready", 256'(if_ready_o), 256'(0));
    chk("arst_valid", 256'(fetch_entry_valid_o), 256'(0));
    chk("arst_entry", 256'(fetch_entry_o), 256'(0));
    mq.delete(); m_out = 0; m_abort = 0;
    @(posedge clk_i);
    #1 chk("arst_hold_valid", 256'(fetch_entry_valid_o), 256'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    fetch_ack_i = 1; dut_grants = 0;
    repeat (6) begin fetch_address_i = pc; cyc_auto(); if (last_ready) pc += 64'd4; end
    chk("post_rst_grants", 256'(dut_grants), 256'(6));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: fetch-entry FIFO depth; power of two, at least 2.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 flush_i  input  1  kill all fetched and in-flight instructions.
REQ-005 fetch_address_i  input  64  PC requested by the PC-generation stage.
REQ-006 fetch_valid_i  input  1  fetch_address_i is valid.
REQ-007 branch_predict_i  input  branchpredict_sbe_t  prediction for fetch_address_i.
REQ-008 if_ready_o  output  1  request accepted this cycle; the PC-generation stage advances its PC.
REQ-009 icache_req_o  output  1  I-cache request.
REQ-010 icache_addr_o  output  64  I-cache request address.
REQ-011 icache_gnt_i  input  1  I-cache accepted the request this cycle.
REQ-012 icache_rvalid_i  input  1  response valid.
REQ-013 icache_rdata_i  input  32  response instruction word.
REQ-014 icache_ex_i  input  1  response carries a fetch access fault; qualified by icache_rvalid_i.
REQ-015 fetch_entry_o  output  fetch_entry_t  head FIFO entry: address, instruction, branch_predict, ex_valid.
REQ-016 fetch_entry_valid_o  output  1  fetch_entry_o is valid.
REQ-017 fetch_ack_i  input  1  consumer pops the head entry.

Function
REQ-018 The I-cache interface SHALL have at most one outstanding request; FSM states are IDLE, WAIT_RVALID and ABORT.
REQ-019 "space" SHALL mean (FIFO count + outstanding response + 1) <= FIFO_DEPTH; a pop in the same cycle SHALL NOT count towards space.
REQ-020 icache_req_o SHALL be driven combinationally as: fetch_valid_i AND space AND NOT flush_i AND (state==IDLE, or state==WAIT_RVALID with icache_rvalid_i this cycle).
REQ-021 icache_addr_o SHALL equal {fetch_address_i[63:2], 2'b00}.
REQ-022 if_ready_o SHALL equal icache_req_o AND icache_gnt_i.
REQ-023 On grant, the block SHALL register fetch_address_i and branch_predict_i as the in-flight tag and go to WAIT_RVALID.
REQ-024 Without a grant, the request SHALL stay asserted while the conditions of REQ-020 hold; the address MAY change between cycles.
REQ-025 In WAIT_RVALID, on icache_rvalid_i the block SHALL push {tag address, icache_rdata_i, tag prediction, icache_ex_i} into the FIFO in the same cycle.
REQ-026 On that push cycle the FSM SHALL go to IDLE, or stay in WAIT_RVALID if a new grant occurs in the same cycle.
REQ-027 When icache_ex_i=1, the pushed entry SHALL have instruction=0, ex_valid=1 and branch_predict.valid=0.
REQ-028 fetch_entry_valid_o SHALL be asserted when the FIFO is not empty; a pop SHALL occur on fetch_entry_valid_o AND fetch_ack_i.
REQ-029 Push and pop in the same cycle SHALL be supported at any fill level, including full.
REQ-030 Push-to-output latency SHALL be one cycle: data arriving at cycle N is visible at cycle N+1.
REQ-031 flush_i SHALL empty the FIFO at the next edge, ignore fetch_ack_i, and suppress icache_req_o and if_ready_o in the flush cycle.
REQ-032 If a request is outstanding at flush (WAIT_RVALID, with no rvalid in the flush cycle), the FSM SHALL go to ABORT.
REQ-033 In ABORT the block SHALL issue no requests; on icache_rvalid_i it SHALL drop the data and go to IDLE.
REQ-034 Flush coinciding with rvalid SHALL drop the data and go to IDLE.
REQ-035 Overflow SHALL be impossible by construction; an assertion SHALL check that no push occurs while the FIFO is full without a simultaneous pop.

Reset
REQ-036 Reset SHALL set the FSM to IDLE, empty the FIFO, clear the tag and discard any outstanding request.
REQ-037 During and after reset: icache_req_o=0, if_ready_o=0, fetch_entry_valid_o=0, fetch_entry_o=0.
REQ-038 Reset mid-operation SHALL assume the I-cache resets in the same domain; no stale rvalid SHALL be expected.

Structure
REQ-039 fetch_entry_t SHALL be defined in ariane_pkg and shared with the decode stage; the FIFO_DEPTH default SHALL be a package constant.
REQ-040 Buffering SHALL be a separate sub-module fetch_fifo, parameterised by type and depth, with a flush port and full/empty/count outputs.

Verification
REQ-041 Back-to-back: grant and rvalid every cycle for 0x80000000, 0x80000004, ... -> one if_ready_o pulse per cycle; entries emerge in order one cycle later.
REQ-042 Backpressure: fetch_ack_i=0 with depth 4 -> exactly 4 grants, then icache_req_o=0; one ack -> exactly one new request.
REQ-043 Grant stall: icache_gnt_i=0 for 3 cycles at 0x1000 -> icache_req_o held high and if_ready_o=0, then a single accept of 0x1000.
REQ-044 Flush in flight: flush in WAIT_RVALID, rvalid 2 cycles later with 0xDEADBEEF -> FIFO empty, no entry output, next request only after the dropped rvalid.
REQ-045 Fault: rvalid with icache_ex_i=1 at 0x2000 -> entry address=0x2000, ex_valid=1, instruction=0, branch_predict.valid=0.
REQ-046 Async reset asserted while 3 entries are buffered and one request is outstanding -> all outputs 0 immediately; normal fetch resumes after deassertion.
